axis_frame_rx: RTL and testbench
================================

// Module: axis_frame_rx
// PURPOSE
// - AXI-Stream slave-side video frame receiver.
// - Accepts a pixel stream (tuser[0]=start of frame, tlast=end of line) and checks it against a fixed image geometry.
// - Emits each accepted pixel with its x/y coordinates and sof/eol/eof markers on a registered valid/ready output.
// - Sits at the ingress of the image pipeline, facing any axi_stream_if master.
// PARAMETERS
// - TDATA_WIDTH_P  32   pixel data width; multiple of 8
// - TUSER_WIDTH_P  1    tuser width; only bit 0 (SOF) is used
// - IMG_WIDTH_P    640  pixels per line; >= 2
// - IMG_HEIGHT_P   480  lines per frame; >= 2
// - XW = $clog2(IMG_WIDTH_P), YW = $clog2(IMG_HEIGHT_P) (localparams)
// PORTS
// - clk            in   1       single clock; all logic on posedge
// - rst            in   1       synchronous, active-high reset
// - s_axis_tvalid  in   1       input beat valid
// - s_axis_tready  out  1       input ready
// - s_axis_tdata   in   TDATA   pixel
// - s_axis_tuser   in   TUSER   [0] = SOF
// - s_axis_tlast   in   1       end of line
// - s_axis_tkeep, s_axis_tstrb, s_axis_tid, s_axis_tdest  in  per-field  ignored
// - out_valid      out  1       output pixel valid
// - out_ready      in   1       downstream ready
// - out_data       out  TDATA   pixel
// - out_x          out  XW      column
// - out_y          out  YW      row
// - out_sof/out_eol/out_eof  out  1 each  first pixel / last of line / last of frame
// - frame_done     out  1       1-cycle pulse when an eof pixel is accepted at the input
// - err_early_eol  out  1       1-cycle pulse: tlast with x < IMG_WIDTH_P-1
// - err_late_eol   out  1       1-cycle pulse: x == IMG_WIDTH_P-1 without tlast
// - err_sof        out  1       1-cycle pulse: SOF seen mid-frame
// - frame_cnt      out  16      frames completed; wraps
// - drop_cnt       out  16      beats discarded while waiting for SOF; saturates at 0xFFFF
// BEHAVIOUR
// - Reset: s_axis_tready=0, out_valid=0, all pulses=0, counters=0, x=y=0, state=WAIT_SOF. Data outputs are don't-care.
//   tready goes to 1 in the first cycle after rst deasserts.
// - Buffering: output register plus one skid register.
//   - s_axis_tready = !skid_valid (registered); no combinational path from out_ready to tready.
//   - Latency: accepted beat appears on out_* the next cycle when the output is empty.
//   - No loss or duplication under any out_ready pattern.
//   - out_* held stable while out_valid && !out_ready.
// - Beat accept = s_axis_tvalid && s_axis_tready. FSM and counters advance only on accept.
// - WAIT_SOF:
//   - Beat with tuser[0]=0: dropped, drop_cnt++, no output.
//   - Beat with tuser[0]=1: emitted as x=0, y=0, sof=1; go to ACTIVE; x=1.
// - ACTIVE, each beat is emitted with the current x/y:
//   - tuser[0]=1 while not at (0,0): err_sof pulses; beat restarts the frame as (0,0) with sof=1.
//   - tlast && x<W-1: err_early_eol pulses; eol=1; x=0, y++.
//   - !tlast && x==W-1: err_late_eol pulses; eol=1 (forced); x=0, y++.
//   - tlast && x==W-1: normal eol; x=0, y++.
//   - eol on y==H-1: eof=1, frame_done pulses, frame_cnt++, x=y=0, go to WAIT_SOF.
//   - Otherwise: x++.
//   - Error precedence when events coincide: err_sof over eol errors. err_sof resets the position first; eol rules then apply at x=0.
// - Multiple error pulses may coincide with frame_done.
// - rst mid-frame: immediately return to the reset state. Buffered pixels are discarded. Next frame needs a fresh SOF.
// TESTING (W=4, H=2)
// 1. 8-beat clean frame, SOF on beat0, tlast on beats 3 and 7, out_ready=1
//    -> 8 outputs, (x,y) (0,0)..(3,1); eof and frame_done on beat 7 only; frame_cnt=1; no errors.
// 2. Same frame, out_ready=1,0,1,0...
//    -> data order intact, none lost or duplicated; tready low only when skid is full; out_* stable while stalled.
// 3. 3 beats without SOF, then a clean frame
//    -> drop_cnt=3; first output is beat 4 with sof=1.
// 4. tlast at x=2 on line 0
//    -> err_early_eol for 1 cycle; next pixel out_x=0, out_y=1.
// 5. SOF at (2,1)
//    -> err_sof; that pixel output as (0,0), sof=1; frame continues from there.
// 6. rst for 1 cycle after beat 5 of a frame
//    -> out_valid=0, tready=0 that cycle; next SOF frame completes with frame_cnt=1.

Source files
------------

// File: rtl/axis_frame_rx.sv
// AXI-Stream video frame receiver: tracks x/y against a fixed geometry, flags
// line/frame framing errors and emits tagged pixels through an output+skid buffer.
module axis_frame_rx #(
  parameter int TDATA_WIDTH_P = 32,
  parameter int TUSER_WIDTH_P = 1,
  parameter int TID_WIDTH_P   = 1,
  parameter int TDEST_WIDTH_P = 1,
  parameter int IMG_WIDTH_P   = 640,
  parameter int IMG_HEIGHT_P  = 480,
  localparam int XW = $clog2(IMG_WIDTH_P),
  localparam int YW = $clog2(IMG_HEIGHT_P)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [TDATA_WIDTH_P-1:0]   s_axis_tdata,
  input  logic [TUSER_WIDTH_P-1:0]   s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic [TDATA_WIDTH_P/8-1:0] s_axis_tkeep,
  input  logic [TDATA_WIDTH_P/8-1:0] s_axis_tstrb,
  input  logic [TID_WIDTH_P-1:0]     s_axis_tid,
  input  logic [TDEST_WIDTH_P-1:0]   s_axis_tdest,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TDATA_WIDTH_P-1:0]   out_data,
  output logic [XW-1:0]              out_x,
  output logic [YW-1:0]              out_y,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       frame_done,
  output logic                       err_early_eol,
  output logic                       err_late_eol,
  output logic                       err_sof,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                drop_cnt
);
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH_P - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT_P - 1);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  typedef struct packed {
    logic [TDATA_WIDTH_P-1:0] data;
    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic                     sof;
    logic                     eol;
    logic                     eof;
  } pix_t;

  state_t          state;
  logic [XW-1:0]   x, cx;
  logic [YW-1:0]   y, cy;
  pix_t            out_r, skid_r, beat;
  logic            skid_valid, skid_nxt, out_free;
  logic            acc, sof_in, emit, eol, eof, early, late;

  logic unused_ok;
  assign unused_ok = ^{s_axis_tkeep, s_axis_tstrb, s_axis_tid, s_axis_tdest, s_axis_tuser};

  always_comb begin
    acc    = s_axis_tvalid && s_axis_tready;
    sof_in = s_axis_tuser[0];
    // SOF always re-anchors the position; line-end rules then see x=0
    cx     = sof_in ? '0 : x;
    cy     = sof_in ? '0 : y;
    early  = s_axis_tlast && (cx != XMAX);
    late   = !s_axis_tlast && (cx == XMAX);
    eol    = s_axis_tlast || (cx == XMAX);
    eof    = eol && (cy == YMAX);
    emit   = acc && ((state == ACTIVE) || sof_in);
    beat   = '{data: s_axis_tdata, x: cx, y: cy, sof: sof_in, eol: eol, eof: eof};
    out_free = !out_valid || out_ready;
    skid_nxt = out_free ? (skid_valid && emit) : (skid_valid || emit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_SOF;
      x             <= '0;
      y             <= '0;
      s_axis_tready <= 1'b0;
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      frame_done    <= 1'b0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_sof       <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      s_axis_tready <= !skid_nxt;
      skid_valid    <= skid_nxt;
      frame_done    <= 1'b0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_sof       <= 1'b0;

      if (out_free) begin
        out_valid <= skid_valid || emit;
        if (skid_valid) begin
          out_r  <= skid_r;
          skid_r <= beat;
        end else begin
          out_r <= beat;
        end
      end else if (emit) begin
        skid_r <= beat;
      end

      if (acc) begin
        if (state == WAIT_SOF && !sof_in) begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          state         <= ACTIVE;
          err_sof       <= sof_in && (state == ACTIVE) && ((x != '0) || (y != '0));
          err_early_eol <= early;
          err_late_eol  <= late;
          if (eof) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            x          <= '0;
            y          <= '0;
            state      <= WAIT_SOF;
          end else if (eol) begin
            x <= '0;
            y <= cy + YW'(1);
          end else begin
            x <= cx + XW'(1);
            y <= cy;
          end
        end
      end
    end
  end

  assign out_data = out_r.data;
  assign out_x    = out_r.x;
  assign out_y    = out_r.y;
  assign out_sof  = out_r.sof;
  assign out_eol  = out_r.eol;
  assign out_eof  = out_r.eof;
endmodule

// File: tb/tb_axis_frame_rx.sv
// Randomized bench for axis_frame_rx (4x2 image) against a queue-based frame model.
module tb_axis_frame_rx;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [0:0]    s_axis_tuser;
  logic [3:0]    s_axis_tkeep, s_axis_tstrb;
  logic [0:0]    s_axis_tid, s_axis_tdest;
  logic          out_valid, out_ready, out_sof, out_eol, out_eof;
  logic [DW-1:0] out_data;
  logic [1:0]    out_x;
  logic [0:0]    out_y;
  logic          frame_done, err_early_eol, err_late_eol, err_sof;
  logic [15:0]   frame_cnt, drop_cnt;

  axis_frame_rx #(.TDATA_WIDTH_P(DW), .TUSER_WIDTH_P(1), .TID_WIDTH_P(1), .TDEST_WIDTH_P(1),
                  .IMG_WIDTH_P(W), .IMG_HEIGHT_P(H)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_x(out_x),
    .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_done(frame_done), .err_early_eol(err_early_eol), .err_late_eol(err_late_eol),
    .err_sof(err_sof), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            sof;
    bit            last;
    bit            rst;
    int            rmode;  // 0: ready high, 1: toggling, 2: random
  } beat_t;

  beat_t       plan[$];
  logic [63:0] expq[$];
  int          n_cmp = 0, n_bad = 0;

  // reference model: frame position as plain integers
  bit          m_active;
  int          col, row, frames, drops;
  logic [3:0]  exp_pulse;  // {done, early, late, sof}
  bit          rst_prev, last_acc;
  int          rmode;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic add(input bit s, input bit l, input int rm);
    plan.push_back('{d: $urandom, sof: s, last: l, rst: 1'b0, rmode: rm});
  endtask

  task automatic add_frame(input int rm);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) add(r == 0 && c == 0, c == W - 1, rm);
  endtask

  task automatic model_reset();
    expq.delete();
    m_active = 0; col = 0; row = 0; frames = 0; drops = 0;
    exp_pulse = '0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit s, input bit l);
    bit at_end, eol, eof;
    if (!m_active && !s) begin
      if (drops < 65535) drops++;
      return;
    end
    if (s) begin
      if (m_active && (col != 0 || row != 0)) exp_pulse[0] = 1'b1;
      col = 0; row = 0;
    end
    m_active = 1;
    at_end = (col == W - 1);
    eol    = l || at_end;
    eof    = eol && (row == H - 1);
    if (l && !at_end) exp_pulse[2] = 1'b1;
    if (!l && at_end) exp_pulse[1] = 1'b1;
    expq.push_back(64'({d, 2'(col), 1'(row), s, eol, eof}));
    if (eof) begin
      exp_pulse[3] = 1'b1;
      frames++;
      m_active = 0; col = 0; row = 0;
    end else if (eol) begin
      col = 0; row++;
    end else begin
      col++;
    end
  endtask

  task automatic check_outputs();
    chk("tready", 64'(s_axis_tready), rst_prev ? 64'(0) : 64'(expq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(expq.size() > 0));
    if (out_valid && expq.size() > 0)
      chk("pixel", 64'({out_data, out_x, out_y, out_sof, out_eol, out_eof}), expq[0]);
    chk("pulses", 64'({frame_done, err_early_eol, err_late_eol, err_sof}), 64'(exp_pulse));
    chk("frame_cnt", 64'(frame_cnt), 64'(frames % 65536));
    chk("drop_cnt", 64'(drop_cnt), 64'(drops));
  endtask

  initial begin
    beat_t b;
    bit    keep, acc, pop;
    int    idle;
    rst = 1'b1; s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 0;
    s_axis_tkeep = '1; s_axis_tstrb = '1; s_axis_tid = '0; s_axis_tdest = '0; out_ready = 0;
    model_reset(); rst_prev = 1; last_acc = 0; rmode = 0; idle = 0;

    add_frame(0);                                  // clean frame, ready high
    add_frame(1);                                  // clean frame, ready toggling
    for (int i = 0; i < 3; i++) add(0, 0, 2);      // beats before any SOF
    add_frame(2);
    add(1, 0, 2); add(0, 0, 2); add(0, 1, 2);      // early eol at x=2
    for (int c = 0; c < W; c++) add(0, c == W - 1, 2);
    for (int c = 0; c < W; c++) add(c == 0, c == W - 1, 2);  // SOF mid-line 1
    add(0, 0, 2); add(0, 0, 2); add(1, 0, 2); add(0, 0, 2); add(0, 0, 2); add(0, 1, 2);
    for (int c = 0; c < W; c++) add(0, c == W - 1, 2);
    for (int i = 0; i < 6; i++) add(i == 0, i == W - 1, 2); // reset mid-frame
    plan.push_back('{d: '0, sof: 1'b0, last: 1'b0, rst: 1'b1, rmode: 2});
    add_frame(2);
    for (int i = 0; i < 300; i++) add($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 2);
    add_frame(2);

    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      check_outputs();

      keep = s_axis_tvalid && !last_acc;
      rst  = 1'b0;
      if (!keep) begin
        s_axis_tvalid = 1'b0;
        if (plan.size() > 0 && (rmode == 0 || $urandom_range(0, 3) != 0)) begin
          b = plan.pop_front();
          rmode = b.rmode;
          if (b.rst) rst = 1'b1;
          else begin
            s_axis_tvalid = 1'b1; s_axis_tdata = b.d;
            s_axis_tuser = b.sof; s_axis_tlast = b.last;
          end
        end
      end
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~out_ready : 1'($urandom_range(0, 1));

      if (rst) begin
        model_reset();
        rst_prev = 1; last_acc = 0;
      end else begin
        acc = s_axis_tvalid && s_axis_tready;
        pop = out_valid && out_ready;
        rst_prev = 0;
        exp_pulse = '0;
        if (pop && expq.size() > 0) void'(expq.pop_front());
        if (acc) model_beat(s_axis_tdata, s_axis_tuser[0], s_axis_tlast);
        last_acc = acc;
      end

      if (plan.size() == 0 && expq.size() == 0 && !s_axis_tvalid) idle++;
      else idle = 0;
      if (idle > 5) break;
    end
    chk("drain_left", 64'(plan.size() + expq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
